boa_pwr_ctl: RTL

//   Parametrised power/reset controller for Boa SoC board tops. Synchronises and debounces N raw

---
 rtl/boa_pwr_pkg.sv | 34 +++
 rtl/boa_pwr_if.sv | 27 ++
 rtl/boa_btn_debounce.sv | 49 ++++
 rtl/boa_pwr_ctl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/boa_pwr_pkg.sv
// Shared types and constants for the Boa power/reset controller.
package boa_pwr_pkg;

    typedef enum logic [2:0] {
        PWR_RESET = 3'd0,
        PWR_RUN   = 3'd1,
        PWR_DRAIN = 3'd2,
        PWR_SHDN  = 3'd3,
        PWR_WAKE  = 3'd4
    } pwr_state_t;

    // Bit positions inside rst_cause {WAKE,BTN,SOFT,POR}
    localparam int unsigned PWR_CAUSE_POR  = 0;
    localparam int unsigned PWR_CAUSE_SOFT = 1;
    localparam int unsigned PWR_CAUSE_BTN  = 2;
    localparam int unsigned PWR_CAUSE_WAKE = 3;

    function automatic logic [3:0] cause_vec(input int unsigned bit_pos);
        logic [3:0] v;
        v = '0;
        v[bit_pos[1:0]] = 1'b1;
        return v;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/boa_pwr_if.sv
// Board/PMU-side signal bundle for the power controller.
interface boa_pwr_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] rst_mask;
    logic [N_BTN-1:0] wake_mask;
    logic             wake_ext;
    logic             pmu_shdn;
    logic             pmu_rst;
    logic             sys_rst;
    logic             clk_en;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_rise;
    logic [2:0]       state;
    logic [3:0]       rst_cause;

    modport master (
        output btn, rst_mask, wake_mask, wake_ext, pmu_shdn, pmu_rst,
        input  sys_rst, clk_en, btn_db, btn_rise, state, rst_cause
    );

    modport slave (
        input  btn, rst_mask, wake_mask, wake_ext, pmu_shdn, pmu_rst,
        output sys_rst, clk_en, btn_db, btn_rise, state, rst_cause
    );
endinterface

// File: rtl/boa_btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser, stability counter,
// debounced level and registered rising-edge pulse.
module boa_btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db,
    output logic btn_rise
);
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

    // Flip the level only after the synchronised value differs for DEB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            btn_db   <= 1'b0;
            btn_rise <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            if (sync == btn_db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt      <= '0;
                btn_db   <= sync;
                btn_rise <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/boa_pwr_ctl.sv
// Power/reset controller: button conditioning, reset stretching,
// PMU shutdown with bus drain, and wake from shutdown.
module boa_pwr_ctl
    import boa_pwr_pkg::*;
#(
    parameter int unsigned N_BTN       = 5,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned RST_CYCLES  = 8,
    parameter int unsigned DRAIN_CYC   = 4,
    parameter bit          WAKE_RESETS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    boa_pwr_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(max3(RST_CYCLES, DRAIN_CYC, DEB_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
    // DRAIN lasts DRAIN_CYC cycles including the entry cycle, so load one less
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYC > 0) ? (DRAIN_CYC - 1) : 0);

    logic [N_BTN-1:0] btn_db_w;
    logic [N_BTN-1:0] btn_rise_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        boa_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn      (bus.btn[i]),
            .btn_db   (btn_db_w[i]),
            .btn_rise (btn_rise_w[i])
        );
    end

    pwr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cause_q, cause_d;
    logic             sys_rst_q, clk_en_q;
    logic             btn_rst, soft_rst, wake_req;

    assign btn_rst  = |(btn_rise_w & bus.rst_mask);
    assign soft_rst = bus.pmu_rst;
    assign wake_req = (|(btn_rise_w & bus.wake_mask)) | bus.wake_ext;

    // Next-state, counter and reset-cause selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            PWR_RESET: begin
                if (cnt_q == '0) state_d = PWR_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            PWR_RUN: begin
                if (btn_rst || soft_rst) begin
                    state_d = PWR_RESET;
                    cnt_d   = RST_LOAD;
                    cause_d = btn_rst ? cause_vec(PWR_CAUSE_BTN) : cause_vec(PWR_CAUSE_SOFT);
                end else if (bus.pmu_shdn) begin
                    if (DRAIN_CYC == 0) begin
                        state_d = PWR_SHDN;
                    end else begin
                        state_d = PWR_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
            end
            PWR_DRAIN: begin
                if (btn_rst || soft_rst) begin
                    state_d = PWR_RESET;
                    cnt_d   = RST_LOAD;
                    cause_d = btn_rst ? cause_vec(PWR_CAUSE_BTN) : cause_vec(PWR_CAUSE_SOFT);
                end else if (cnt_q == '0) begin
                    state_d = PWR_SHDN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PWR_SHDN: begin
                if (btn_rst) begin
                    state_d = PWR_RESET;
                    cnt_d   = RST_LOAD;
                    cause_d = cause_vec(PWR_CAUSE_BTN);
                end else if (wake_req) begin
                    state_d = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                if (WAKE_RESETS) begin
                    state_d = PWR_RESET;
                    cnt_d   = RST_LOAD;
                    cause_d = cause_vec(PWR_CAUSE_WAKE);
                end else begin
                    state_d = PWR_RUN;
                end
            end
            default: begin
                state_d = PWR_RESET;
                cnt_d   = RST_LOAD;
            end
        endcase
    end

    // State, counter and registered outputs (clk_en only moves on the clock edge)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWR_RESET;
            cnt_q     <= RST_LOAD;
            cause_q   <= cause_vec(PWR_CAUSE_POR);
            sys_rst_q <= 1'b1;
            clk_en_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            sys_rst_q <= (state_d == PWR_RESET);
            clk_en_q  <= (state_d != PWR_SHDN);
        end
    end

    assign bus.sys_rst   = sys_rst_q;
    assign bus.clk_en    = clk_en_q;
    assign bus.btn_db    = btn_db_w;
    assign bus.btn_rise  = btn_rise_w;
    assign bus.state     = state_q;
    assign bus.rst_cause = cause_q;
endmodule
